// File: rtl/multiplexor_display.sv
// Scans a 16-bit value onto one shared 4-bit digit bus for a 4-digit common-anode display.
// The displayed value only changes at a sweep boundary, so a single sweep never mixes two values.
module multiplexor_display #(
    parameter int PRESCALER = 50000,
    parameter int ANCHO_PRE = 16
) (
    input  logic        reloj,
    input  logic        reinicio_n,
    input  logic [15:0] valor,
    input  logic        cargar,
    input  logic        supr_ceros,
    input  logic        habilitar,
    output logic [3:0]  digito,
    output logic [3:0]  anodos,
    output logic [1:0]  indice,
    output logic        fin_barrido
);

    generate
        if (PRESCALER < 2) begin : g_err_prescaler
            $error("multiplexor_display: PRESCALER must be >= 2");
        end
        if ((ANCHO_PRE < 1) || (ANCHO_PRE < $clog2(PRESCALER))) begin : g_err_ancho
            $error("multiplexor_display: ANCHO_PRE too narrow for PRESCALER");
        end
    endgenerate

    localparam logic [ANCHO_PRE-1:0] PRE_ULT = ANCHO_PRE'(PRESCALER - 1);
    localparam logic [ANCHO_PRE-1:0] PRE_UNO = ANCHO_PRE'(1);

    logic [ANCHO_PRE-1:0] r_pre;
    logic [1:0]           r_indice;
    logic [3:0]           r_digito;
    logic [3:0]           r_anodos;
    logic                 r_fin;
    logic [15:0]          r_mostrado;
    logic [15:0]          r_pendiente;
    logic                 r_pend_valido;

    logic                 w_tick;
    logic                 w_wrap;
    logic [1:0]           w_indice_sig;
    logic [15:0]          w_valor_nuevo;
    logic                 w_blank;
    logic [3:0]           w_anodos_sig;

    function automatic logic [3:0] nibble_de(input logic [15:0] v, input logic [1:0] k);
        case (k)
            2'd0:    nibble_de = v[3:0];
            2'd1:    nibble_de = v[7:4];
            2'd2:    nibble_de = v[11:8];
            default: nibble_de = v[15:12];
        endcase
    endfunction

    // A slot is a leading zero when it and every more significant nibble are zero.
    function automatic logic es_cero_izq(input logic [15:0] v, input logic [1:0] k);
        case (k)
            2'd0:    es_cero_izq = 1'b0;
            2'd1:    es_cero_izq = (v[15:4] == 12'h000);
            2'd2:    es_cero_izq = (v[15:8] == 8'h00);
            default: es_cero_izq = (v[15:12] == 4'h0);
        endcase
    endfunction

    assign w_tick        = habilitar && (r_pre == PRE_ULT);
    assign w_wrap        = w_tick && (r_indice == 2'd3);
    assign w_indice_sig  = r_indice + 2'd1;
    assign w_valor_nuevo = (w_wrap && r_pend_valido) ? r_pendiente : r_mostrado;
    assign w_blank       = supr_ceros && es_cero_izq(r_mostrado, r_indice);
    assign w_anodos_sig  = (habilitar && !w_blank) ? ~(4'b0001 << r_indice) : 4'b1111;

    // Anodes follow the registered slot index, giving the one-clock lag behind the digit bus.
    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            r_pre         <= '0;
            r_indice      <= 2'd0;
            r_digito      <= 4'h0;
            r_anodos      <= 4'b1111;
            r_fin         <= 1'b0;
            r_mostrado    <= 16'h0000;
            r_pendiente   <= 16'h0000;
            r_pend_valido <= 1'b0;
        end else begin
            if (habilitar) begin
                r_pre <= (r_pre == PRE_ULT) ? '0 : r_pre + PRE_UNO;
            end
            if (w_tick) begin
                r_indice <= w_indice_sig;
                r_digito <= nibble_de(w_valor_nuevo, w_indice_sig);
            end
            if (w_wrap && r_pend_valido) begin
                r_mostrado <= r_pendiente;
            end
            if (cargar) begin
                r_pendiente   <= valor;
                r_pend_valido <= 1'b1;
            end else if (w_wrap) begin
                r_pend_valido <= 1'b0;
            end
            r_fin    <= w_wrap;
            r_anodos <= w_anodos_sig;
        end
    end

    assign digito      = r_digito;
    assign anodos      = r_anodos;
    assign indice      = r_indice;
    assign fin_barrido = r_fin;

endmodule

// File: tb/tb_multiplexor_display.sv
// Directed bench for multiplexor_display with PRESCALER=4: per-cycle expectations are queued
// ahead of time and popped one clock at a time as the design advances.
module tb_multiplexor_display;

    logic        reloj;
    logic        reinicio_n;
    logic [15:0] valor;
    logic        cargar;
    logic        supr_ceros;
    logic        habilitar;
    logic [3:0]  digito;
    logic [3:0]  anodos;
    logic [1:0]  indice;
    logic        fin_barrido;

    typedef struct {
        logic [3:0] d;
        logic [3:0] a;
        logic [1:0] i;
        logic       f;
    } esperado_t;

    esperado_t cola[$];
    int        n_vec;
    int        n_err;

    multiplexor_display #(.PRESCALER(4), .ANCHO_PRE(3)) dut (
        .reloj       (reloj),
        .reinicio_n  (reinicio_n),
        .valor       (valor),
        .cargar      (cargar),
        .supr_ceros  (supr_ceros),
        .habilitar   (habilitar),
        .digito      (digito),
        .anodos      (anodos),
        .indice      (indice),
        .fin_barrido (fin_barrido)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic comparar(input string tag, input logic [3:0] d, input logic [3:0] a,
                            input logic [1:0] i, input logic f);
        n_vec++;
        assert (digito === d) else begin
            n_err++;
            $error("FAIL %s.digito: got %h expected %h", tag, digito, d);
        end
        n_vec++;
        assert (anodos === a) else begin
            n_err++;
            $error("FAIL %s.anodos: got %b expected %b", tag, anodos, a);
        end
        n_vec++;
        assert (indice === i) else begin
            n_err++;
            $error("FAIL %s.indice: got %0d expected %0d", tag, indice, i);
        end
        n_vec++;
        assert (fin_barrido === f) else begin
            n_err++;
            $error("FAIL %s.fin_barrido: got %b expected %b", tag, fin_barrido, f);
        end
    endtask

    task automatic empujar(input logic [3:0] d, input logic [3:0] a, input logic [1:0] i,
                           input logic f);
        esperado_t e;
        e.d = d; e.a = a; e.i = i; e.f = f;
        cola.push_back(e);
    endtask

    // Expected outputs after the j-th edge of a sweep that began with the wrap edge (j=0).
    task automatic empujar_barrido(input logic [15:0] v, input logic supr, input logic [3:0] an0,
                                   input int jdesde, input int jhasta);
        for (int j = jdesde; j <= jhasta; j++) begin
            int         s;
            int         p;
            logic [3:0] a;
            logic [15:0] resto;
            s = j / 4;
            if (j == 0) begin
                a = an0;
            end else begin
                p = (j - 1) / 4;
                resto = v >> (4 * p);
                if (supr && (p > 0) && (resto == 16'h0000)) a = 4'b1111;
                else a = ~(4'b0001 << p);
            end
            empujar(4'((v >> (4 * s)) & 16'hF), a, 2'(s), (j == 0));
        end
    endtask

    task automatic ciclo(input string tag);
        esperado_t e;
        @(posedge reloj);
        #1;
        if (cola.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: got empty scoreboard expected an entry", tag);
        end else begin
            e = cola.pop_front();
            comparar(tag, e.d, e.a, e.i, e.f);
        end
    endtask

    task automatic correr(input string tag, input int n);
        repeat (n) ciclo(tag);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reinicio_n = 1'b1;
        valor      = 16'h0000;
        cargar     = 1'b0;
        supr_ceros = 1'b0;
        habilitar  = 1'b1;
        #2;
        reinicio_n = 1'b0;
        #1;
        comparar("reset_async", 4'h0, 4'b1111, 2'd0, 1'b0);
        @(posedge reloj);
        @(posedge reloj);
        #1;
        comparar("reset_held", 4'h0, 4'b1111, 2'd0, 1'b0);

        // Release reset and queue 12AF for the first wrap.
        reinicio_n = 1'b1;
        valor      = 16'h12AF;
        cargar     = 1'b1;
        empujar_barrido(16'h0000, 1'b0, 4'b1111, 1, 15);
        ciclo("sweep0");
        cargar = 1'b0;
        correr("sweep0", 14);

        empujar_barrido(16'h12AF, 1'b0, 4'b0111, 0, 15);
        correr("show_12AF", 16);

        empujar_barrido(16'h12AF, 1'b0, 4'b0111, 0, 15);
        ciclo("rerun_12AF");
        ciclo("rerun_12AF");
        valor      = 16'h0005;
        cargar     = 1'b1;
        supr_ceros = 1'b1;
        ciclo("rerun_12AF");
        cargar = 1'b0;
        correr("rerun_12AF", 13);

        empujar_barrido(16'h0005, 1'b1, 4'b0111, 0, 15);
        correr("blank_0005", 16);
        supr_ceros = 1'b0;

        empujar_barrido(16'h0005, 1'b0, 4'b0111, 0, 15);
        ciclo("lit_0005");
        ciclo("lit_0005");
        valor  = 16'h1234;
        cargar = 1'b1;
        ciclo("lit_0005");
        cargar = 1'b0;
        correr("lit_0005", 13);

        // Load BEEF exactly on the wrap edge that transfers 1234.
        valor  = 16'hBEEF;
        cargar = 1'b1;
        empujar_barrido(16'h1234, 1'b0, 4'b0111, 0, 15);
        ciclo("show_1234");
        cargar = 1'b0;
        correr("show_1234", 15);

        empujar_barrido(16'hBEEF, 1'b0, 4'b0111, 0, 15);
        ciclo("show_BEEF");
        ciclo("show_BEEF");
        valor  = 16'h1111;
        cargar = 1'b1;
        ciclo("show_BEEF");
        valor  = 16'h2222;
        ciclo("show_BEEF");
        cargar = 1'b0;
        correr("show_BEEF", 12);

        // Freeze for 10 clocks one clock into slot 0.
        empujar_barrido(16'h2222, 1'b0, 4'b0111, 0, 1);
        for (int k = 0; k < 10; k++) empujar(4'h2, 4'b1111, 2'd0, 1'b0);
        empujar_barrido(16'h2222, 1'b0, 4'b0111, 2, 15);
        ciclo("last_wins");
        ciclo("last_wins");
        habilitar = 1'b0;
        correr("frozen", 10);
        habilitar = 1'b1;
        correr("resume", 14);

        empujar_barrido(16'h2222, 1'b0, 4'b0111, 0, 5);
        ciclo("pre_reset");
        ciclo("pre_reset");
        ciclo("pre_reset");
        valor  = 16'h7777;
        cargar = 1'b1;
        ciclo("pre_reset");
        cargar = 1'b0;
        ciclo("pre_reset");
        ciclo("pre_reset");

        #2;
        reinicio_n = 1'b0;
        #1;
        comparar("reset_mid_async", 4'h0, 4'b1111, 2'd0, 1'b0);
        @(posedge reloj);
        #1;
        comparar("reset_mid_held", 4'h0, 4'b1111, 2'd0, 1'b0);
        reinicio_n = 1'b1;

        empujar_barrido(16'h0000, 1'b0, 4'b1111, 1, 15);
        correr("after_reset", 15);
        empujar_barrido(16'h0000, 1'b0, 4'b0111, 0, 15);
        correr("pending_dropped", 16);

        n_vec++;
        assert (cola.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: got %0d left expected 0", cola.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
